pebble_mc_core: RTL and testbench
=================================

# pebble_mc_core

Parametrised multi-cycle successor to the Pebble single-cycle processor top. It runs the same 9-bit Pebble ISA through a fetch/decode/execute state machine, with configurable data and PC widths. It adds a start/done handshake with a busy indicator and external synchronous-read instruction and data memory ports. It sits at the Pebble top level and replaces the combinational datapath; the memories sit outside it.

## Interface
- DW, 8: data and register width (≥8); also data-memory address width.
- PCW, 10: program counter and instruction-address width (≥5).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to run from PC=0.
- busy  out  1  high from the cycle after an accepted start until the HALT state is entered.
- done  out  1  high in the HALT state.
- imem_addr  out  PCW  instruction address.
- imem_rdata  in  9  instruction; valid one cycle after imem_addr.
- dm_addr  out  DW  data address.
- dm_wdata  out  DW  store data.
- dm_we  out  1  store strobe, one cycle per store.
- dm_rdata  in  DW  load data; valid one cycle after dm_addr.

## Operation
- Register file: 4 × DW registers, r0–r3; all reset to 0.
- Instruction register IR.
- Encoding, field IR[8:7]:
  - 00 R-type: rd=IR[3:2], rs=IR[1:0], op=IR[6:4]; rd ← rd op rs.
    - op 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
    - op 101 SHL1 (rd ← rs<<1), 110 SHR1 logical (rd ← rs>>1), 111 MOV (rd ← rs).
  - 01 LI: rd=IR[6:5]; rd ← zero-extended IR[4:0].
  - 10 MEM: IR[6]=1 load, IR[6]=0 store; ra=IR[3:2] (address), rd/rs=IR[1:0] (data). IR[5:4] are ignored.
  - 11 BRANCH: IR[6:0]=7'h7F is HALT. Otherwise BEQZ: if r[IR[1:0]]==0 then PC ← r[IR[3:2]][PCW-1:0], zero-extended when DW<PCW; else PC+1.
- Arithmetic is modulo 2^DW; no flags are kept.
- PC+1 wraps modulo 2^PCW.
- FSM states: IDLE, FETCH, DECODE, EXEC, LDWB, HALT.
  - IDLE: start=1 → PC←0, go to FETCH.
  - FETCH: imem_addr=PC; go to DECODE.
  - DECODE: IR←imem_rdata; go to EXEC.
  - EXEC:
    - R/LI: write rd, PC+1, go to FETCH.
    - Store: dm_we=1, dm_addr=r[ra], dm_wdata=r[rs], PC+1, go to FETCH.
    - Load: dm_addr=r[ra], go to LDWB.
    - BEQZ: update PC, go to FETCH.
    - HALT: go to HALT; PC is unchanged.
  - LDWB: rd ← dm_rdata, PC+1, go to FETCH.
  - HALT: done=1. start=1 → PC←0, go to FETCH (restart; registers are retained).
- start is ignored in FETCH/DECODE/EXEC/LDWB.

## Timing
- Reset values: state IDLE, PC=0, IR=0, registers 0, busy=0, done=0, dm_we=0, imem_addr=0, dm_addr=0, dm_wdata=0.
- dm_addr and dm_wdata hold their last driven values outside EXEC.
- Start accepted at edge N → FETCH in cycle N+1; busy high from N+1.
- Cycles per instruction: R, LI, store, BEQZ, HALT take 3 each; load takes 4.
- Register writes are visible to the next instruction's EXEC; there is no hazard logic because execution is strictly sequential.
- done rises the cycle after HALT's EXEC and busy falls in the same cycle. After a restart, done falls in the cycle after start is sampled.
- Reset asserted in any state returns to the reset values on the next edge, including a store in EXEC: dm_we is 0 the cycle after reset is sampled. Reset overrides a simultaneous start.

## Configuration
- PEBBLE_CYCLE_CNT_EN defined:
  - Adds output `cycle_count` [31:0], reset 0.
  - Clears to 0 when a start is accepted.
  - Increments every cycle while busy=1 and saturates at 32'hFFFFFFFF.
  - Holds its value in HALT/IDLE.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold reset 3 cycles with start=1 → all outputs 0, busy=0, no fetch activity.
- ALU/store program (DW=8): LI r0,5; LI r1,7; ADD r0,r1; ST [r2],r0; HALT → exactly one dm_we pulse with dm_addr=0, dm_wdata=8'h0C. done rises 15 cycles after start is accepted; cycle_count=15 when the macro is defined.
- Width/wrap (DW=16): LI r0,0; LI r1,1; SUB r0,r1; ST [r2],r0 → dm_wdata=16'hFFFF. Also run a PC wrap check with PCW=5: the instruction at 31 is followed by a fetch at 0.
- Load latency: dm_rdata model returns 8'hA5 for address 3. LI r3,3; LD r0,[r3]; LI r1,4; ST [r1],r0 → store of A5 at address 4. The load occupies 4 cycles.
- Branch: BEQZ with r1=0 and target r2=6 → next imem_addr=6. With r1=1 → next imem_addr=PC+1.
- Control: start pulsed mid-program → ignored. Reset asserted during the store's EXEC → dm_we=0 the next cycle and state IDLE. start in HALT → done=0 next cycle and the program re-runs from 0.

Source files
------------

// File: rtl/pebble_mc_core_if.sv
// pebble_mc_core_if
//   Bundles the Pebble core's control handshake and its two memory ports.
//   Parameters: DW (data/register width, also data address width),
//               PCW (program counter / instruction address width).
//   Signals:
//     start      host -> core   single-cycle run request (PC restarts at 0)
//     busy       core -> host   program running
//     done       core -> host   core sits in HALT
//     imem_addr  core -> imem   instruction address
//     imem_rdata imem -> core   9-bit instruction, one cycle after imem_addr
//     dm_addr    core -> dmem   data address
//     dm_wdata   core -> dmem   store data
//     dm_we      core -> dmem   store strobe
//     dm_rdata   dmem -> core   load data, one cycle after dm_addr
//   Modports: master = core side, slave = host/memory side.
interface pebble_mc_core_if #(
    parameter int DW  = 8,
    parameter int PCW = 10
);
    logic           start;
    logic           busy;
    logic           done;
    logic [PCW-1:0] imem_addr;
    logic [8:0]     imem_rdata;
    logic [DW-1:0]  dm_addr;
    logic [DW-1:0]  dm_wdata;
    logic           dm_we;
    logic [DW-1:0]  dm_rdata;

    modport master (
        input  start, imem_rdata, dm_rdata,
        output busy, done, imem_addr, dm_addr, dm_wdata, dm_we
    );

    modport slave (
        output start, imem_rdata, dm_rdata,
        input  busy, done, imem_addr, dm_addr, dm_wdata, dm_we
    );
endinterface

// File: rtl/pebble_mc_core.sv
// pebble_mc_core
//   Multi-cycle Pebble processor: runs the 9-bit Pebble ISA through a
//   FETCH/DECODE/EXEC(/LDWB) sequence against external synchronous-read
//   instruction and data memories.
//   Parameters: DW (>=8) data/register width, PCW (>=5) PC width.
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous, active-high
//     bus          pebble_mc_core_if.master (start/busy/done + memory ports)
//     cycle_count  [31:0] saturating busy-cycle counter, only when the
//                  PEBBLE_CYCLE_CNT_EN macro is defined
module pebble_mc_core #(
    parameter int DW  = 8,
    parameter int PCW = 10
) (
    input  logic              clk,
    input  logic              reset,
    pebble_mc_core_if.master  bus
`ifdef PEBBLE_CYCLE_CNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_LDWB,
        S_HALT
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [8:0]     ir_q, ir_d;
    logic [DW-1:0]  rf_q [4];
    logic [DW-1:0]  rf_d [4];
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [DW-1:0]  dm_addr_q, dm_addr_d;
    logic [DW-1:0]  dm_wdata_q, dm_wdata_d;
    logic           dm_we_q, dm_we_d;

    logic [DW-1:0]  rd_val, rs_val, alu_res;
    logic [PCW-1:0] pc_inc, br_tgt;
    logic           start_acc;

    assign rd_val    = rf_q[ir_q[3:2]];
    assign rs_val    = rf_q[ir_q[1:0]];
    assign pc_inc    = pc_q + PCW'(1);
    assign start_acc = bus.start && (state_q == S_IDLE || state_q == S_HALT);

    // Branch target is r[IR[3:2]] truncated or zero-extended to PCW.
    if (DW >= PCW) begin : g_tgt_trunc
        assign br_tgt = rd_val[PCW-1:0];
    end else begin : g_tgt_zext
        assign br_tgt = {{(PCW-DW){1'b0}}, rd_val};
    end

    always_comb begin
        alu_res = '0;
        case (ir_q[6:4])
            3'b000: alu_res = rd_val + rs_val;
            3'b001: alu_res = rd_val - rs_val;
            3'b010: alu_res = rd_val & rs_val;
            3'b011: alu_res = rd_val | rs_val;
            3'b100: alu_res = rd_val ^ rs_val;
            3'b101: alu_res = {rs_val[DW-2:0], 1'b0};
            3'b110: alu_res = {1'b0, rs_val[DW-1:1]};
            3'b111: alu_res = rs_val;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        rf_d       = rf_q;
        busy_d     = busy_q;
        done_d     = done_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_we_d    = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = bus.imem_rdata;
                state_d = S_EXEC;
                // Memory outputs are registered, so they are set up from the
                // incoming instruction here to be valid throughout EXEC.
                if (bus.imem_rdata[8:7] == 2'b10) begin
                    dm_addr_d = rf_q[bus.imem_rdata[3:2]];
                    if (!bus.imem_rdata[6]) begin
                        dm_wdata_d = rf_q[bus.imem_rdata[1:0]];
                        dm_we_d    = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (ir_q[8:7])
                    2'b00: rf_d[ir_q[3:2]] = alu_res;
                    2'b01: rf_d[ir_q[6:5]] = {{(DW-5){1'b0}}, ir_q[4:0]};
                    2'b10: begin
                        if (ir_q[6]) begin
                            state_d = S_LDWB;
                            pc_d    = pc_q;
                        end
                    end
                    default: begin
                        if (ir_q[6:0] == 7'h7F) begin
                            state_d = S_HALT;
                            pc_d    = pc_q;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (rs_val == '0) begin
                            pc_d = br_tgt;
                        end
                    end
                endcase
            end
            S_LDWB: begin
                rf_d[ir_q[1:0]] = bus.dm_rdata;
                pc_d            = pc_inc;
                state_d         = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PEBBLE_CYCLE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else if (busy_q && cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign cycle_count = cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_we_q    <= 1'b0;
`ifdef PEBBLE_CYCLE_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            rf_q       <= rf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_we_q    <= dm_we_d;
`ifdef PEBBLE_CYCLE_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.imem_addr = pc_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_wdata  = dm_wdata_q;
    assign bus.dm_we     = dm_we_q;

endmodule

// File: tb/tb_pebble_mc_core.sv
// tb_pebble_mc_core
//   Drives two pebble_mc_core instances (DW=8/PCW=10 and DW=16/PCW=5) with
//   small programs held in bench-side synchronous memories. Expected stores
//   are queued when a program is loaded and matched as dm_we pulses appear.
module tb_pebble_mc_core;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pebble_mc_core_if #(.DW(8),  .PCW(10)) bus8 ();
    pebble_mc_core_if #(.DW(16), .PCW(5))  bus16 ();

`ifdef PEBBLE_CYCLE_CNT_EN
    logic [31:0] cc8, cc16;
`endif

    pebble_mc_core #(.DW(8), .PCW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
`ifdef PEBBLE_CYCLE_CNT_EN
        ,
        .cycle_count (cc8)
`endif
    );

    pebble_mc_core #(.DW(16), .PCW(5)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
`ifdef PEBBLE_CYCLE_CNT_EN
        ,
        .cycle_count (cc16)
`endif
    );

    localparam logic [8:0] HALT = 9'h1FF;

    logic [8:0]  imem8  [1024];
    logic [7:0]  dmem8  [256];
    logic [8:0]  imem16 [32];
    logic [15:0] dmem16 [256];

    always @(posedge clk) begin
        bus8.imem_rdata <= imem8[bus8.imem_addr];
        bus8.dm_rdata   <= dmem8[bus8.dm_addr];
        if (bus8.dm_we) dmem8[bus8.dm_addr] <= bus8.dm_wdata;
        bus16.imem_rdata <= imem16[bus16.imem_addr];
        bus16.dm_rdata   <= dmem16[bus16.dm_addr[7:0]];
        if (bus16.dm_we) dmem16[bus16.dm_addr[7:0]] <= bus16.dm_wdata;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] enc_r(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
        return {2'b00, op, rd, rs};
    endfunction
    function automatic logic [8:0] enc_li(input logic [1:0] rd, input logic [4:0] imm);
        return {2'b01, rd, imm};
    endfunction
    function automatic logic [8:0] enc_ld(input logic [1:0] ra, input logic [1:0] rd);
        return {2'b10, 1'b1, 2'b00, ra, rd};
    endfunction
    function automatic logic [8:0] enc_st(input logic [1:0] ra, input logic [1:0] rs);
        return {2'b10, 1'b0, 2'b00, ra, rs};
    endfunction
    function automatic logic [8:0] enc_bz(input logic [1:0] rt, input logic [1:0] rc);
        return {2'b11, 3'b000, rt, rc};
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    st_t q8[$];
    st_t q16[$];
    st_t e8, e16;
    int n_push8 = 0, n_seen8 = 0, n_push16 = 0, n_seen16 = 0;

    task automatic push8(input logic [31:0] a, input logic [31:0] d);
        st_t e;
        e.addr = a;
        e.data = d;
        q8.push_back(e);
        n_push8++;
    endtask

    always @(negedge clk) begin
        if (bus8.dm_we === 1'b1) begin
            n_seen8++;
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                check_val("st8_addr", 32'(bus8.dm_addr), e8.addr);
                check_val("st8_data", 32'(bus8.dm_wdata), e8.data);
            end
        end
        if (bus16.dm_we === 1'b1) begin
            n_seen16++;
            if (q16.size() > 0) begin
                e16 = q16.pop_front();
                check_val("st16_addr", 32'(bus16.dm_addr), e16.addr);
                check_val("st16_data", 32'(bus16.dm_wdata), e16.data);
            end
        end
    end

    task automatic clear_imem8();
        for (int i = 0; i < 1024; i++) imem8[i] = HALT;
    endtask

    int unsigned alog8 [300];

    // Pulse start, then count cycles from the first FETCH until done.
    task automatic run8(input string name, input int exp_cyc, input int mid_k);
        int cyc;
        @(negedge clk);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check_val({name, "_busy_rise"}, 32'(bus8.busy), 32'd1);
        check_val({name, "_done_low"}, 32'(bus8.done), 32'd0);
        check_val({name, "_fetch0"}, 32'(bus8.imem_addr), 32'd0);
        cyc = 0;
        while (bus8.done !== 1'b1 && cyc < 300) begin
            alog8[cyc] = bus8.imem_addr;
            bus8.start = (cyc == mid_k);
            @(negedge clk);
            cyc++;
        end
        bus8.start = 1'b0;
        check_val({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check_val({name, "_busy_fall"}, 32'(bus8.busy), 32'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        bus8.start = 1'b1;
        bus16.start = 1'b1;
        clear_imem8();
        for (int i = 0; i < 32; i++) imem16[i] = HALT;
        for (int i = 0; i < 256; i++) begin
            dmem8[i]  = 8'(i);
            dmem16[i] = 16'(i);
        end
        dmem8[3] = 8'hA5;

        // Reset held with start asserted.
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(bus8.busy), 32'd0);
        check_val("rst_done", 32'(bus8.done), 32'd0);
        check_val("rst_we", 32'(bus8.dm_we), 32'd0);
        check_val("rst_iaddr", 32'(bus8.imem_addr), 32'd0);
        check_val("rst_daddr", 32'(bus8.dm_addr), 32'd0);
        check_val("rst_wdata", 32'(bus8.dm_wdata), 32'd0);
        check_val("rst16_busy", 32'(bus16.busy), 32'd0);
        check_val("rst16_we", 32'(bus16.dm_we), 32'd0);
`ifdef PEBBLE_CYCLE_CNT_EN
        check_val("rst_cnt", cc8, 32'd0);
`endif
        reset = 1'b0;
        bus8.start = 1'b0;
        bus16.start = 1'b0;
        @(negedge clk);
        check_val("idle_busy", 32'(bus8.busy), 32'd0);
        check_val("idle_iaddr", 32'(bus8.imem_addr), 32'd0);

        // ALU/store program.
        imem8[0] = enc_li(2'd0, 5'd5);
        imem8[1] = enc_li(2'd1, 5'd7);
        imem8[2] = enc_r(3'b000, 2'd0, 2'd1);
        imem8[3] = enc_st(2'd2, 2'd0);
        imem8[4] = HALT;
        push8(32'd0, 32'h0C);
        run8("alu", 15, -1);
`ifdef PEBBLE_CYCLE_CNT_EN
        check_val("alu_cnt", cc8, 32'd15);
        @(negedge clk);
        check_val("alu_cnt_hold", cc8, 32'd15);
`endif

        // Load latency (restart from HALT).
        clear_imem8();
        imem8[0] = enc_li(2'd3, 5'd3);
        imem8[1] = enc_ld(2'd3, 2'd0);
        imem8[2] = enc_li(2'd1, 5'd4);
        imem8[3] = enc_st(2'd1, 2'd0);
        push8(32'd4, 32'hA5);
        run8("ld", 16, -1);
        check_val("ld_next_fetch", alog8[7], 32'd2);

        // Branch taken: r1=0, target r2=6.
        clear_imem8();
        imem8[0] = enc_li(2'd1, 5'd0);
        imem8[1] = enc_li(2'd2, 5'd6);
        imem8[2] = enc_bz(2'd2, 2'd1);
        imem8[6] = enc_st(2'd2, 2'd2);
        push8(32'd6, 32'd6);
        run8("bz_taken", 15, -1);
        check_val("bz_taken_pc", alog8[9], 32'd6);

        // Branch not taken: r1=1.
        clear_imem8();
        imem8[0] = enc_li(2'd1, 5'd1);
        imem8[1] = enc_li(2'd2, 5'd6);
        imem8[2] = enc_bz(2'd2, 2'd1);
        imem8[3] = enc_st(2'd1, 2'd2);
        push8(32'd1, 32'd6);
        run8("bz_not", 15, -1);
        check_val("bz_not_pc", alog8[9], 32'd3);

        // start pulsed during a store's EXEC is ignored.
        clear_imem8();
        imem8[0] = enc_li(2'd2, 5'd0);
        imem8[1] = enc_li(2'd0, 5'd1);
        imem8[2] = enc_st(2'd2, 2'd0);
        push8(32'd0, 32'd1);
        run8("mid_start", 12, 8);

        // Reset during a store's EXEC.
        clear_imem8();
        imem8[0] = enc_li(2'd0, 5'd9);
        imem8[1] = enc_st(2'd0, 2'd0);
        push8(32'd9, 32'd9);
        @(negedge clk);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rexec_we", 32'(bus8.dm_we), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rexec_we_clr", 32'(bus8.dm_we), 32'd0);
        check_val("rexec_busy", 32'(bus8.busy), 32'd0);
        check_val("rexec_iaddr", 32'(bus8.imem_addr), 32'd0);
        check_val("rexec_daddr", 32'(bus8.dm_addr), 32'd0);
        @(negedge clk);
        check_val("rexec_idle", 32'(bus8.busy), 32'd0);

        // Registers are cleared by reset: store r1 to [r0].
        clear_imem8();
        imem8[0] = enc_st(2'd0, 2'd1);
        push8(32'd0, 32'd0);
        run8("post_rst", 6, -1);

        // DW=16 subtraction wrap plus PCW=5 PC wrap from 31 to 0.
        imem16[0] = enc_li(2'd0, 5'd0);
        imem16[1] = enc_li(2'd1, 5'd1);
        imem16[2] = enc_r(3'b001, 2'd0, 2'd1);
        imem16[3] = enc_st(2'd2, 2'd0);
        imem16[4] = enc_li(2'd3, 5'd31);
        imem16[5] = enc_bz(2'd3, 2'd2);
        imem16[31] = enc_li(2'd1, 5'd3);
        e16.addr = 32'd0;
        e16.data = 32'hFFFF;
        q16.push_back(e16);
        n_push16++;
        @(negedge clk);
        bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        check_val("w16_busy", 32'(bus16.busy), 32'd1);
        cyc = 0;
        while (bus16.done !== 1'b1 && cyc < 300) begin
            if (cyc < 32) alog8[cyc] = bus16.imem_addr;
            if (bus16.imem_addr == 5'd31) imem16[0] = HALT;
            @(negedge clk);
            cyc++;
        end
        check_val("w16_cycles", 32'(cyc), 32'd24);
        check_val("w16_pc31", alog8[18], 32'd31);
        check_val("w16_wrap0", alog8[21], 32'd0);
`ifdef PEBBLE_CYCLE_CNT_EN
        check_val("w16_cnt", cc16, 32'd24);
`endif

        @(negedge clk);
        check_val("st8_count", 32'(n_seen8), 32'(n_push8));
        check_val("st16_count", 32'(n_seen16), 32'(n_push16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
